dbg_log_arb: RTL

Round-robin, packet-aware arbiter merging the concatenated log streams of N daisy-chained `dbg_guv` instances into one AXI-Stream log output for offload. Each flit is tagged with its source index. Once an input starts a packet, it holds the output until its TLAST flit. A 2-entry output buffer gives full throughput and a registered output stage.

---
 rtl/dbg_log_arb_pkg.sv | 17 +
 rtl/axis_skid2.sv | 63 ++++++
 rtl/dbg_log_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dbg_log_arb_pkg.sv
// Shared types for the debug log arbiter: arbiter state encoding and a clog2 helper.
// Pure declarations; no logic, no latency.
package dbg_log_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// 2-entry AXI-Stream buffer with registered output; latency 1 cycle from write to out_TVALID.
// in_TREADY is registered (not full), drops only when both slots hold data, returns the cycle after a read.
module axis_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_TDATA,
    input  logic             in_TVALID,
    output logic             in_TREADY,
    output logic [WIDTH-1:0] out_TDATA,
    output logic             out_TVALID,
    input  logic             out_TREADY
);

    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       wpos;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             rdy_q, rdy_d;
    logic             wr, rd;

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign in_TREADY  = rdy_q & rst;
    assign out_TVALID = (cnt_q != 2'd0);
    assign out_TDATA  = head_q;

    assign wr   = in_TVALID & in_TREADY;
    assign rd   = out_TVALID & out_TREADY;
    assign wpos = cnt_q - {1'b0, rd};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + {1'b0, wr} - {1'b0, rd};
        if (rd && cnt_q == 2'd2) begin
            head_d = tail_q;
        end
        if (wr) begin
            if (wpos == 2'd0) begin
                head_d = in_TDATA;
            end else begin
                tail_d = in_TDATA;
            end
        end
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rdy_q  <= rdy_d;
        end
    end

endmodule

// File: rtl/dbg_log_arb.sv
// Packet-aware round-robin merge of N log streams into one tagged stream; latency 1 cycle.
// An open packet keeps its grant through any out_TREADY stall; inputs stall only when the 2-entry buffer is full.
module dbg_log_arb
    import dbg_log_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int LOG_WIDTH = 51,
    parameter int SRC_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN*LOG_WIDTH-1:0] in_TDATA,
    input  logic [N_IN-1:0]           in_TVALID,
    output logic [N_IN-1:0]           in_TREADY,
    input  logic [N_IN-1:0]           in_TLAST,
    output logic [LOG_WIDTH-1:0]      out_TDATA,
    output logic                      out_TVALID,
    input  logic                      out_TREADY,
    output logic                      out_TLAST,
    output logic [SRC_WIDTH-1:0]      out_TSRC
);

    localparam int BUF_W = LOG_WIDTH + 1 + SRC_WIDTH;

    arb_state_e           state_q, state_d;
    logic [SRC_WIDTH-1:0] gnt_q, gnt_d;
    logic [SRC_WIDTH-1:0] ptr_q, ptr_d;

    logic [SRC_WIDTH-1:0] win;
    logic                 win_vld;
    logic [SRC_WIDTH-1:0] sel;
    logic                 sel_act;
    logic                 sel_vld;
    logic                 sel_last;
    logic [LOG_WIDTH-1:0] sel_dat;
    logic                 acc;
    logic                 buf_rdy;
    logic [BUF_W-1:0]     buf_in;
    logic [BUF_W-1:0]     buf_out;

    // Two descending passes: the lowest valid index overall, overridden by the lowest one at or above ptr.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_TVALID[i]) begin
                win     = SRC_WIDTH'(i);
                win_vld = 1'b1;
            end
        end
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_TVALID[i] && (SRC_WIDTH'(i) >= ptr_q)) begin
                win = SRC_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel      = (state_q == ST_LOCK) ? gnt_q : win;
        sel_act  = (state_q == ST_LOCK) || win_vld;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        in_TREADY = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SRC_WIDTH'(i)) begin
                sel_vld      = in_TVALID[i];
                sel_last     = in_TLAST[i];
                sel_dat      = in_TDATA[i*LOG_WIDTH +: LOG_WIDTH];
                in_TREADY[i] = sel_act & buf_rdy;
            end
        end
    end

    assign acc    = sel_act & sel_vld & buf_rdy;
    assign buf_in = {sel, sel_last, sel_dat};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (acc && !sel_last) begin
                    state_d = ST_LOCK;
                    gnt_d   = sel;
                end
            end
            ST_LOCK: begin
                if (acc && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc && sel_last) begin
            ptr_d = (sel == SRC_WIDTH'(N_IN - 1)) ? '0 : sel + SRC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    axis_skid2 #(
        .WIDTH(BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_TDATA  (buf_in),
        .in_TVALID (sel_act & sel_vld),
        .in_TREADY (buf_rdy),
        .out_TDATA (buf_out),
        .out_TVALID(out_TVALID),
        .out_TREADY(out_TREADY)
    );

    assign {out_TSRC, out_TLAST, out_TDATA} = buf_out;

endmodule
